// File: rtl/ram_clr_dxwb_rw_r_pn.sv
// Byte-writable RAM (port A read/write, port B read-only) with a post-reset clear sweep,
// read latency 1 or 2, and byte-merged write-first forwarding. Optional parity: RAM_PARITY_EN.
module ram_clr_dxwb_rw_r_pn #(
    parameter int unsigned      DEPTH          = 4096,
    parameter int unsigned      WIDTH          = 32,
    parameter int unsigned      READ_LATENCY   = 1,
    parameter bit               CLEAR_ON_RESET = 1'b1,
    parameter logic [WIDTH-1:0] CLEAR_VALUE    = '0,
    localparam int unsigned     ADDR_BITS      = $clog2(DEPTH),
    localparam int unsigned     BE_BITS        = WIDTH / 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    output logic                 ready,
    input  logic [ADDR_BITS-1:0] address_a,
    input  logic                 wren_a,
    input  logic [BE_BITS-1:0]   byteena_a,
    input  logic [WIDTH-1:0]     data_a,
    input  logic                 rden_a,
    output logic [WIDTH-1:0]     q_a,
    output logic                 q_a_valid,
    input  logic [ADDR_BITS-1:0] address_b,
    input  logic                 rden_b,
    output logic [WIDTH-1:0]     q_b,
    output logic                 q_b_valid
`ifdef RAM_PARITY_EN
    ,
    input  logic                 err_inject_a,
    output logic                 parity_err_a,
    output logic                 parity_err_b
`endif
);

    typedef enum logic {StClear, StRun} state_e;

    localparam logic [ADDR_BITS-1:0] LastAddr = ADDR_BITS'(DEPTH - 1);

    state_e                 r_state;
    logic [ADDR_BITS-1:0]   r_cnt;
    logic                   r_ready;
    logic [WIDTH-1:0]       r_mem [DEPTH];

    logic                   w_wr_a, w_rd_a, w_rd_b, w_clr, w_hit_b;
    logic [ADDR_BITS-1:0]   w_mem_addr;
    logic [WIDTH-1:0]       w_mem_data;
    logic [BE_BITS-1:0]     w_mem_be;
    logic [WIDTH-1:0]       w_rdata_a, w_rdata_b;

    assign ready  = r_ready;
    assign w_clr  = (r_state == StClear);
    assign w_wr_a = r_ready & wren_a;
    assign w_rd_a = r_ready & rden_a;
    assign w_rd_b = r_ready & rden_b;

    // The sweep owns the single write port while ready is low.
    assign w_mem_addr = w_clr ? r_cnt : address_a;
    assign w_mem_data = w_clr ? CLEAR_VALUE : data_a;
    assign w_mem_be   = w_clr ? {BE_BITS{1'b1}} : (w_wr_a ? byteena_a : '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= CLEAR_ON_RESET ? StClear : StRun;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                StClear: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LastAddr) begin
                        r_state <= StRun;
                        r_ready <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                default: r_ready <= 1'b1;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        for (int unsigned i = 0; i < BE_BITS; i++) begin
            if (w_mem_be[i]) r_mem[w_mem_addr][8*i +: 8] <= w_mem_data[8*i +: 8];
        end
    end

    // Write-first forwarding: written bytes replace the stored ones on a same-address read.
    always_comb begin
        w_rdata_a = r_mem[address_a];
        w_rdata_b = r_mem[address_b];
        w_hit_b   = w_wr_a && (address_b == address_a);
        for (int unsigned i = 0; i < BE_BITS; i++) begin
            if (w_wr_a && byteena_a[i])  w_rdata_a[8*i +: 8] = data_a[8*i +: 8];
            if (w_hit_b && byteena_a[i]) w_rdata_b[8*i +: 8] = data_a[8*i +: 8];
        end
    end

`ifdef RAM_PARITY_EN
    logic [BE_BITS-1:0] r_par [DEPTH];
    logic [BE_BITS-1:0] w_new_par, w_clr_par, w_rpar_a, w_rpar_b;
    logic               w_perr_a, w_perr_b;

    always_comb begin
        w_rpar_a = r_par[address_a];
        w_rpar_b = r_par[address_b];
        for (int unsigned i = 0; i < BE_BITS; i++) begin
            w_new_par[i] = (^data_a[8*i +: 8]) ^ err_inject_a;
            w_clr_par[i] = ^CLEAR_VALUE[8*i +: 8];
            if (w_wr_a && byteena_a[i])  w_rpar_a[i] = w_new_par[i];
            if (w_hit_b && byteena_a[i]) w_rpar_b[i] = w_new_par[i];
        end
        w_perr_a = 1'b0;
        w_perr_b = 1'b0;
        for (int unsigned i = 0; i < BE_BITS; i++) begin
            w_perr_a = w_perr_a | ((^w_rdata_a[8*i +: 8]) ^ w_rpar_a[i]);
            w_perr_b = w_perr_b | ((^w_rdata_b[8*i +: 8]) ^ w_rpar_b[i]);
        end
    end

    always_ff @(posedge clock) begin
        for (int unsigned i = 0; i < BE_BITS; i++) begin
            if (w_mem_be[i]) r_par[w_mem_addr][i] <= w_clr ? w_clr_par[i] : w_new_par[i];
        end
    end

    logic r_s1_pe_a, r_s1_pe_b;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_pe_a <= 1'b0;
            r_s1_pe_b <= 1'b0;
        end else begin
            r_s1_pe_a <= w_rd_a & w_perr_a;
            r_s1_pe_b <= w_rd_b & w_perr_b;
        end
    end
`endif

    logic [WIDTH-1:0] r_s1_a, r_s1_b;
    logic             r_s1_va, r_s1_vb;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_a  <= '0;
            r_s1_b  <= '0;
            r_s1_va <= 1'b0;
            r_s1_vb <= 1'b0;
        end else begin
            r_s1_va <= w_rd_a;
            r_s1_vb <= w_rd_b;
            if (w_rd_a) r_s1_a <= w_rdata_a;
            if (w_rd_b) r_s1_b <= w_rdata_b;
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic [WIDTH-1:0] r_s2_a, r_s2_b;
        logic             r_s2_va, r_s2_vb;
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                r_s2_a  <= '0;
                r_s2_b  <= '0;
                r_s2_va <= 1'b0;
                r_s2_vb <= 1'b0;
            end else begin
                r_s2_va <= r_s1_va;
                r_s2_vb <= r_s1_vb;
                if (r_s1_va) r_s2_a <= r_s1_a;
                if (r_s1_vb) r_s2_b <= r_s1_b;
            end
        end
        assign q_a       = r_s2_a;
        assign q_b       = r_s2_b;
        assign q_a_valid = r_s2_va;
        assign q_b_valid = r_s2_vb;
`ifdef RAM_PARITY_EN
        logic r_s2_pe_a, r_s2_pe_b;
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                r_s2_pe_a <= 1'b0;
                r_s2_pe_b <= 1'b0;
            end else begin
                r_s2_pe_a <= r_s1_pe_a;
                r_s2_pe_b <= r_s1_pe_b;
            end
        end
        assign parity_err_a = r_s2_pe_a;
        assign parity_err_b = r_s2_pe_b;
`endif
    end else begin : g_lat1
        assign q_a       = r_s1_a;
        assign q_b       = r_s1_b;
        assign q_a_valid = r_s1_va;
        assign q_b_valid = r_s1_vb;
`ifdef RAM_PARITY_EN
        assign parity_err_a = r_s1_pe_a;
        assign parity_err_b = r_s1_pe_b;
`endif
    end

endmodule

// File: tb/tb_ram_clr_dxwb_rw_r_pn.sv
// Bench: latency-1 and latency-2 instances share stimulus and are compared every cycle
// against a behavioural memory model, plus literal expectations for the directed cases.
module tb_ram_clr_dxwb_rw_r_pn;
    localparam int          DEPTH = 16;
    localparam logic [31:0] CLR   = 32'hA5A5A5A5;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic [3:0]  address_a = '0, address_b = '0, byteena_a = '0;
    logic        wren_a = 1'b0, rden_a = 1'b0, rden_b = 1'b0;
    logic [31:0] data_a = '0;
    logic        ready1, qav1, qbv1, ready2, qav2, qbv2;
    logic [31:0] qa1, qb1, qa2, qb2;
`ifdef RAM_PARITY_EN
    logic        err_inject_a = 1'b0;
    logic        pea1, peb1, pea2, peb2;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    ram_clr_dxwb_rw_r_pn #(.DEPTH(DEPTH), .WIDTH(32), .READ_LATENCY(1),
        .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(CLR)) u_dut1 (
        .clock(clock), .reset_n(reset_n), .ready(ready1),
        .address_a(address_a), .wren_a(wren_a), .byteena_a(byteena_a), .data_a(data_a),
        .rden_a(rden_a), .q_a(qa1), .q_a_valid(qav1),
        .address_b(address_b), .rden_b(rden_b), .q_b(qb1), .q_b_valid(qbv1)
`ifdef RAM_PARITY_EN
        , .err_inject_a(err_inject_a), .parity_err_a(pea1), .parity_err_b(peb1)
`endif
    );

    ram_clr_dxwb_rw_r_pn #(.DEPTH(DEPTH), .WIDTH(32), .READ_LATENCY(2),
        .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(CLR)) u_dut2 (
        .clock(clock), .reset_n(reset_n), .ready(ready2),
        .address_a(address_a), .wren_a(wren_a), .byteena_a(byteena_a), .data_a(data_a),
        .rden_a(rden_a), .q_a(qa2), .q_a_valid(qav2),
        .address_b(address_b), .rden_b(rden_b), .q_b(qb2), .q_b_valid(qbv2)
`ifdef RAM_PARITY_EN
        , .err_inject_a(err_inject_a), .parity_err_a(pea2), .parity_err_b(peb2)
`endif
    );

    // Model: edges since release, memory contents, and the last two read results per port.
    logic [31:0] m_mem [DEPTH];
    int          m_edges;
    logic        m_rdy;
    logic        h_aa [2], h_ab [2];
    logic [31:0] h_da [2], h_db [2];
    logic        e_va [2], e_vb [2];
    logic [31:0] e_qa [2], e_qb [2];

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_edges = 0;
            for (int k = 0; k < 2; k++) begin
                h_aa[k] = 1'b0; h_ab[k] = 1'b0; h_da[k] = '0; h_db[k] = '0;
                e_va[k] = 1'b0; e_vb[k] = 1'b0; e_qa[k] = '0; e_qb[k] = '0;
            end
        end else begin
            m_rdy = (m_edges >= DEPTH);
            if (!m_rdy) m_mem[m_edges] = CLR;
            else if (wren_a) begin
                for (int i = 0; i < 4; i++)
                    if (byteena_a[i]) m_mem[address_a][8*i +: 8] = data_a[8*i +: 8];
            end
            // A same-edge read sees memory after this edge's write.
            h_aa[1] = h_aa[0]; h_da[1] = h_da[0];
            h_ab[1] = h_ab[0]; h_db[1] = h_db[0];
            h_aa[0] = m_rdy && rden_a; h_da[0] = m_mem[address_a];
            h_ab[0] = m_rdy && rden_b; h_db[0] = m_mem[address_b];
            for (int l = 0; l < 2; l++) begin
                e_va[l] = h_aa[l];
                e_vb[l] = h_ab[l];
                if (h_aa[l]) e_qa[l] = h_da[l];
                if (h_ab[l]) e_qb[l] = h_db[l];
            end
            if (m_edges < DEPTH) m_edges++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        check("m_ready1", 32'(ready1), 32'(m_edges >= DEPTH));
        check("m_ready2", 32'(ready2), 32'(m_edges >= DEPTH));
        check("m_qa1", qa1, e_qa[0]);  check("m_qav1", 32'(qav1), 32'(e_va[0]));
        check("m_qb1", qb1, e_qb[0]);  check("m_qbv1", 32'(qbv1), 32'(e_vb[0]));
        check("m_qa2", qa2, e_qa[1]);  check("m_qav2", 32'(qav2), 32'(e_va[1]));
        check("m_qb2", qb2, e_qb[1]);  check("m_qbv2", 32'(qbv2), 32'(e_vb[1]));
`ifdef RAM_PARITY_EN
        check("m_perr", 32'({pea1, peb1, pea2, peb2}), 32'd0);
`endif
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic idle();
        wren_a = 1'b0; rden_a = 1'b0; rden_b = 1'b0; byteena_a = '0;
    endtask

    task automatic write_a(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        wren_a = 1'b1; address_a = a; data_a = d; byteena_a = be;
    endtask

    // Release reset, confirm ready timing, and show a write at the last sweep edge is dropped.
    task automatic sweep_and_check();
        reset_n = 1'b1;
        repeat (DEPTH - 1) step();
        check("sweep_busy1", 32'(ready1), 32'd0);
        check("sweep_busy2", 32'(ready2), 32'd0);
        write_a(4'd0, 32'h12345678, 4'hF);
        step();
        check("sweep_done1", 32'(ready1), 32'd1);
        check("sweep_done2", 32'(ready2), 32'd1);
        idle();
        rden_a = 1'b1; address_a = 4'd0;
        step();
        check("lost_write", qa1, CLR);
        idle();
    endtask

    initial begin
        #1 reset_n = 1'b0;
        step(); step();
        check("rst_ready", 32'(ready1), 32'd0);
        check("rst_qa", qa1, 32'd0);
        check("rst_qbv", 32'(qbv2), 32'd0);
        sweep_and_check();

        for (int i = 0; i < DEPTH; i++) begin
            rden_a = 1'b1; address_a = 4'(i);
            rden_b = 1'b1; address_b = 4'(DEPTH - 1 - i);
            step();
            check("clr_read_a", qa1, CLR);
        end
        idle(); step(); step();

        write_a(4'd5, 32'hDEADBEEF, 4'hF); step(); idle();
        rden_a = 1'b1; address_a = 4'd5; step(); idle();
        check("rd5_q1", qa1, 32'hDEADBEEF);
        check("rd5_v1", 32'(qav1), 32'd1);
        step();
        check("rd5_v1_pulse", 32'(qav1), 32'd0);
        check("rd5_q2", qa2, 32'hDEADBEEF);
        check("rd5_v2", 32'(qav2), 32'd1);

        write_a(4'd5, 32'h00005500, 4'b0010); step(); idle();
        rden_b = 1'b1; address_b = 4'd5; step(); idle();
        check("byte_merge", qb1, 32'hDEAD55EF);

        write_a(4'd7, 32'hAABBCCDD, 4'hF); step();
        write_a(4'd7, 32'h11223344, 4'b1100);
        rden_b = 1'b1; address_b = 4'd7; step(); idle();
        check("fwd_b", qb1, 32'h1122CCDD);
        rden_a = 1'b1; address_a = 4'd7; step(); idle();
        check("fwd_later", qa1, 32'h1122CCDD);
        step(); step();

        for (int i = 0; i < 4; i++) begin
            rden_b = 1'b1; address_b = 4'(i);
            step();
            if (i == 0) check("b2b_v_early", 32'(qbv2), 32'd0);
            else begin
                check("b2b_v", 32'(qbv2), 32'd1);
                check("b2b_q", qb2, CLR);
            end
        end
        idle(); step();
        check("b2b_v_last", 32'(qbv2), 32'd1);
        step();
        check("b2b_v_end", 32'(qbv2), 32'd0);

        repeat (600) begin
            wren_a    = 1'($urandom_range(0, 1));
            rden_a    = 1'($urandom_range(0, 1));
            rden_b    = 1'($urandom_range(0, 1));
            address_a = 4'($urandom_range(0, 7));
            address_b = 4'($urandom_range(0, 7));
            byteena_a = 4'($urandom);
            data_a    = $urandom;
            step();
        end
        idle(); step();

        reset_n = 1'b0; step();
        reset_n = 1'b1;
        repeat (8) step();
        rden_a = 1'b1;
        reset_n = 1'b0;
        #1;
        check("midrst_ready", 32'(ready1), 32'd0);
        check("midrst_qa", qa1, 32'd0);
        check("midrst_qb2", qb2, 32'd0);
        step(); idle();
        sweep_and_check();

        for (int i = 0; i < DEPTH; i++) begin
            rden_b = 1'b1; address_b = 4'(i);
            step();
        end
        idle(); step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
